// File: rtl/cmd_frame_if.sv
// cmd_frame_if: byte-stream in / assembled-frame out bundle for cmd_frame_assembler.
//   en, clear      - capture enable, synchronous abort
//   in_byte        - data byte, stable across a byte_toggle edge
//   byte_toggle    - each edge (either direction) marks one new byte
//   frame_ack      - consumer accepts the held frame
//   frame          - last completed frame, first byte in the MSB byte
//   frame_valid    - frame held and not yet acked
//   byte_idx       - index of the next byte expected
//   overrun        - sticky, a frame completed while one was still held
//   timeout_err    - one-cycle pulse when a partial frame is dropped
//   crc_ok         - CRC status of the held frame
interface cmd_frame_if #(
  parameter int FRAME_BYTES = 6
);
  logic                     en;
  logic                     clear;
  logic [7:0]               in_byte;
  logic                     byte_toggle;
  logic                     frame_ack;
  logic [8*FRAME_BYTES-1:0] frame;
  logic                     frame_valid;
  logic [3:0]               byte_idx;
  logic                     overrun;
  logic                     timeout_err;
  logic                     crc_ok;

  modport master (
    output en, clear, in_byte, byte_toggle, frame_ack,
    input  frame, frame_valid, byte_idx, overrun, timeout_err, crc_ok
  );

  modport slave (
    input  en, clear, in_byte, byte_toggle, frame_ack,
    output frame, frame_valid, byte_idx, overrun, timeout_err, crc_ok
  );
endinterface

// File: rtl/cmd_frame_assembler.sv
// cmd_frame_assembler: collects FRAME_BYTES toggle-signalled bytes into one
// frame, hands it downstream with a valid/ack handshake, flags overrun and
// inter-byte timeout.
//   clk    - system clock, posedge
//   reset  - asynchronous active-low reset
//   bus    - cmd_frame_if.slave (byte stream in, frame + status out)
// Optional feature: define CMD_CRC7_CHECK_EN to compile in the SD CRC7 check
// (poly x^7+x^3+1, init 0, MSB first) over bytes 0..FRAME_BYTES-2; the last
// byte must carry {crc7, 1'b1}. Without it crc_ok simply follows frame_valid.
module cmd_frame_assembler #(
  parameter int FRAME_BYTES    = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  cmd_frame_if.slave  bus
);

  localparam logic [3:0]       LAST_IDX = 4'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);

  // byte i lives in slot FRAME_BYTES-1-i so byte 0 ends up in the MSB byte
  logic [FRAME_BYTES-1:0][7:0] shift_q, shift_d, new_frame;
  logic [8*FRAME_BYTES-1:0]    frame_q, frame_d;
  logic [3:0]                  byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        prev_toggle_q, prev_toggle_d;
  logic                        armed_q, armed_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        overrun_q, overrun_d;
  logic                        timeout_err_q, timeout_err_d;
  logic                        evt, accept, complete;

`ifdef CMD_CRC7_CHECK_EN
  logic [6:0] crc_q, crc_d;
  logic       crc_ok_q, crc_ok_d;

  // eight MSB-first serial steps unrolled into one byte-wide update
  function automatic logic [6:0] crc7_byte(input logic [6:0] c_in, input logic [7:0] b);
    logic [6:0] c;
    logic       fb;
    c = c_in;
    for (int k = 7; k >= 0; k--) begin
      fb = c[6] ^ b[k];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction
`endif

  always_comb begin
    prev_toggle_d = bus.byte_toggle;   // tracked every cycle, so en gaps never fake an edge
    armed_d       = 1'b1;
    shift_d       = shift_q;
    frame_d       = frame_q;
    byte_idx_d    = byte_idx_q;
    cnt_d         = cnt_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    timeout_err_d = 1'b0;

    evt      = armed_q & (bus.byte_toggle ^ prev_toggle_q);
    accept   = evt & bus.en & ~bus.clear;
    complete = accept && (byte_idx_q == LAST_IDX);

    new_frame = shift_q;
    for (int i = 0; i < FRAME_BYTES; i++)
      if (byte_idx_q == 4'(i)) new_frame[FRAME_BYTES-1-i] = bus.in_byte;

    // byte counting and inter-byte timeout; an accepted byte beats the timeout
    if (accept) begin
      shift_d    = new_frame;
      byte_idx_d = complete ? 4'd0 : byte_idx_q + 4'd1;
      cnt_d      = '0;
    end else if (byte_idx_q == 4'd0) begin
      cnt_d = '0;
    end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_MAX) begin
      byte_idx_d    = 4'd0;
      cnt_d         = '0;
      timeout_err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // output handoff: an ack in the completion cycle frees the slot for the new frame
    if (complete) begin
      if (!frame_valid_q || bus.frame_ack) begin
        frame_d       = new_frame;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.frame_ack && frame_valid_q) begin
      frame_valid_d = 1'b0;
    end

    if (bus.clear) begin
      byte_idx_d    = 4'd0;
      frame_valid_d = 1'b0;
      overrun_d     = 1'b0;
      cnt_d         = '0;
      timeout_err_d = 1'b0;
    end
  end

`ifdef CMD_CRC7_CHECK_EN
  always_comb begin
    crc_d    = crc_q;
    crc_ok_d = crc_ok_q;
    if (accept && !complete)
      crc_d = crc7_byte((byte_idx_q == 4'd0) ? 7'd0 : crc_q, bus.in_byte);
    else if (byte_idx_q == 4'd0)
      crc_d = 7'd0;
    // crc_ok moves only when frame itself is replaced
    if (complete && (!frame_valid_q || bus.frame_ack))
      crc_ok_d = (crc_q == bus.in_byte[7:1]) && bus.in_byte[0];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_toggle_q <= 1'b0;
      armed_q       <= 1'b0;
      shift_q       <= '0;
      frame_q       <= '0;
      byte_idx_q    <= 4'd0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef CMD_CRC7_CHECK_EN
      crc_q         <= 7'd0;
      crc_ok_q      <= 1'b0;
`endif
    end else begin
      prev_toggle_q <= prev_toggle_d;
      armed_q       <= armed_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      byte_idx_q    <= byte_idx_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
`ifdef CMD_CRC7_CHECK_EN
      crc_q         <= crc_d;
      crc_ok_q      <= crc_ok_d;
`endif
    end
  end

  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.byte_idx    = byte_idx_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;
`ifdef CMD_CRC7_CHECK_EN
  assign bus.crc_ok      = crc_ok_q;
`else
  assign bus.crc_ok      = frame_valid_q;
`endif

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Scoreboard bench for cmd_frame_assembler (FRAME_BYTES=6, TIMEOUT_CYCLES=1024).
// Stimulus pushes each frame that should reach the output; a negedge monitor
// pops and compares whenever a new frame is presented.
module tb_cmd_frame_assembler;

  typedef struct {
    logic [47:0] f;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   to_pulses = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  cmd_frame_if #(.FRAME_BYTES(6)) bus ();

  cmd_frame_assembler #(
    .FRAME_BYTES(6), .TIMEOUT_CYCLES(1024), .CNT_W(11)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected crc_ok: bit-serial CRC7 over the first five bytes
  function automatic logic exp_ok(input logic [47:0] f);
`ifdef CMD_CRC7_CHECK_EN
    logic [6:0] c = 7'd0;
    logic       fb;
    for (int i = 47; i >= 8; i--) begin
      fb = c[6] ^ f[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'b0001001;
    end
    return (c == f[7:1]) && f[0];
`else
    return 1'b1;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic ack);
    @(negedge clk);
    bus.in_byte     = b;
    bus.byte_toggle = ~bus.byte_toggle;
    bus.frame_ack   = ack;
    @(negedge clk);
    bus.frame_ack   = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input bit expect_out, input logic ack_last);
    exp_t e;
    if (expect_out) begin
      e.f  = f;
      e.ok = exp_ok(f);
      q.push_back(e);
    end
    for (int i = 0; i < 6; i++)
      send_byte(f[47-8*i -: 8], (i == 5) ? ack_last : 1'b0);
  endtask

  task automatic do_ack();
    @(negedge clk); bus.frame_ack = 1'b1;
    @(negedge clk); bus.frame_ack = 1'b0;
    chk("valid_after_ack", 64'(bus.frame_valid), 64'd0);
  endtask

  // monitor: a frame is presented when valid rises or the held data changes
  logic        pv = 1'b0;
  logic [47:0] pf = '0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.timeout_err) to_pulses++;
    if (!reset) pv = 1'b0;
    else begin
      if (bus.frame_valid && (!pv || bus.frame !== pf)) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got %0h expected none", bus.frame);
        end else begin
          e = q.pop_front();
          chk("frame", 64'(bus.frame), 64'(e.f));
          chk("crc_ok", 64'(bus.crc_ok), 64'(e.ok));
        end
      end
      pv = bus.frame_valid;
      pf = bus.frame;
    end
  end

  initial begin
    int p0;
    bus.en = 1'b1; bus.clear = 1'b0; bus.in_byte = 8'h00;
    bus.byte_toggle = 1'b0; bus.frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame", 64'(bus.frame), 64'd0);
    chk("rst_valid", 64'(bus.frame_valid), 64'd0);
    chk("rst_idx", 64'(bus.byte_idx), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    chk("rst_timeout", 64'(bus.timeout_err), 64'd0);
    chk("rst_crc_ok", 64'(bus.crc_ok), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idx_after_arm", 64'(bus.byte_idx), 64'd0);

    // CMD0 with correct CRC, then a corrupted last byte
    send_frame(48'h400000000095, 1, 1'b0);
    chk("valid_A", 64'(bus.frame_valid), 64'd1);
    do_ack();
    send_frame(48'h400000000094, 1, 1'b0);
    do_ack();

    // back-to-back without ack: second frame dropped, overrun set
    send_frame(48'h112233445566, 1, 1'b0);
    send_frame(48'h778899AABBCC, 0, 1'b0);
    chk("ovr_frame_held", 64'(bus.frame), 64'h112233445566);
    chk("ovr_flag", 64'(bus.overrun), 64'd1);
    chk("ovr_valid", 64'(bus.frame_valid), 64'd1);
    @(negedge clk); bus.clear = 1'b1;
    @(negedge clk); bus.clear = 1'b0;
    chk("clr_overrun", 64'(bus.overrun), 64'd0);
    chk("clr_valid", 64'(bus.frame_valid), 64'd0);
    chk("clr_frame_kept", 64'(bus.frame), 64'h112233445566);

    // ack coincident with the last byte of the next frame
    send_frame(48'h0102030405A1, 1, 1'b0);
    send_frame(48'h48000001AA87, 1, 1'b1);
    chk("ackc_valid", 64'(bus.frame_valid), 64'd1);
    chk("ackc_overrun", 64'(bus.overrun), 64'd0);
    chk("ackc_frame", 64'(bus.frame), 64'h48000001AA87);
    do_ack();

    // inter-byte timeout after a partial frame
    send_byte(8'h40, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    chk("to_idx3", 64'(bus.byte_idx), 64'd3);
    p0 = to_pulses;
    repeat (1100) @(negedge clk);
    chk("to_pulses", 64'(to_pulses - p0), 64'd1);
    chk("to_idx0", 64'(bus.byte_idx), 64'd0);
    send_frame(48'h400000000095, 1, 1'b0);
    do_ack();

    // toggles while en=0 are not captured and cause no event on re-enable
    send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0);
    bus.en = 1'b0;
    send_byte(8'hEE, 1'b0); send_byte(8'hEF, 1'b0);
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_idx", 64'(bus.byte_idx), 64'd2);
    send_byte(8'hA3, 1'b0); send_byte(8'hA4, 1'b0); send_byte(8'hA5, 1'b0);
    begin
      exp_t e; e.f = 48'hA1A2A3A4A5A6; e.ok = exp_ok(e.f); q.push_back(e);
    end
    send_byte(8'hA6, 1'b0);
    do_ack();

    // reset mid-frame: partial bytes discarded
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("midrst_idx", 64'(bus.byte_idx), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(48'h400000000095, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("pending", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_frame_assembler.md
Name: cmd_frame_assembler

Overview:
Parametrised successor to the fixed 4-byte command capture. Assembles FRAME_BYTES bytes from a toggle-signalled byte stream (SPI/SD command path of the cart) into one frame. Hands the frame downstream with a valid/ack handshake and flags overrun and inter-byte timeout. An optional CRC7 check (SD command CRC) can be compiled in.

Parameters:
FRAME_BYTES, 6, bytes per frame (2..16); byte 0 lands in the MSB byte of frame.
TIMEOUT_CYCLES, 1024, max clk cycles between bytes of one frame; 0 disables the timeout.
CNT_W, 11, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset (asserts immediately, released synchronously to clk).
en  in  1  when low, byte events are ignored; the partial frame is kept.
clear  in  1  synchronous abort: flushes the partial frame, clears frame_valid and overrun.
in_byte  in  8  data byte, stable when byte_toggle changes.
byte_toggle  in  1  any edge (0->1 or 1->0) marks one new byte.
frame_ack  in  1  consumer accepts the held frame.
frame  out  8*FRAME_BYTES  last completed frame, MSB byte = first received.
frame_valid  out  1  frame held and not yet acked.
byte_idx  out  4  index of the next byte expected (0..FRAME_BYTES-1).
overrun  out  1  sticky: a frame completed while frame_valid=1.
timeout_err  out  1  one-cycle pulse when a partial frame is discarded by timeout.
crc_ok  out  1  CRC7 result for the held frame; meaning defined under Optional Feature.

Behaviour:
- Reset values: frame=0, frame_valid=0, byte_idx=0, overrun=0, timeout_err=0, crc_ok=0, timeout counter=0, prev_toggle=0, armed=0.
- First clk after reset release: prev_toggle<=byte_toggle, armed<=1. No byte is counted on that cycle.
- Byte event = armed & (byte_toggle ^ prev_toggle). prev_toggle<=byte_toggle every armed cycle, regardless of en, so there is no spurious event when en is re-enabled.
- Accepted event (event & en & !clear): in_byte is written to shift slot byte_idx. byte_idx increments, or wraps to 0 after FRAME_BYTES-1.
- Completion is the accepted event at byte_idx=FRAME_BYTES-1. The next cycle, the assembled frame is offered to the output (latency 1 clk).
  - If frame_valid=0, or frame_ack=1 in the completion cycle: frame<=new data, frame_valid<=1.
  - Otherwise: the new frame is dropped, frame is unchanged, overrun<=1.
- frame_ack with frame_valid=1 and no completion: frame_valid<=0 next cycle. frame_ack with frame_valid=0 is ignored.
- Timeout:
  - The counter resets to 0 on every accepted event and whenever byte_idx=0.
  - Otherwise it increments each clk, including while en=0.
  - When the counter reaches TIMEOUT_CYCLES: byte_idx<=0, counter<=0, timeout_err=1 for one cycle.
  - An accepted event in the same cycle wins; it is counted and there is no timeout.
- clear has priority over everything except reset: byte_idx<=0, frame_valid<=0, overrun<=0, counter<=0. frame data is retained.
- Reset mid-frame discards the partial frame, and the next frame starts at byte 0.

Optional Feature:
Macro CMD_CRC7_CHECK_EN.
- Defined:
  - CRC7 (poly x^7+x^3+1, init 0, MSB-first) runs byte-parallel over bytes 0..FRAME_BYTES-2 as they are accepted, and resets at byte_idx=0.
  - At completion, crc_ok<=(crc7 == last_byte[7:1]) && last_byte[0]==1. crc_ok updates together with frame.
- Undefined: no CRC logic; crc_ok is driven 1 whenever frame_valid=1, else 0.

Test Plan:
- Reset, toggle 6 times with 40 00 00 00 00 95 -> frame=0x400000000095, frame_valid=1 one clk after the 6th event. With CMD_CRC7_CHECK_EN, crc_ok=1.
- Same frame with last byte 0x94 and the macro defined -> crc_ok=0. Without the macro -> crc_ok=1.
- Two frames back to back, no frame_ack -> frame holds frame 1, overrun=1. Then assert clear -> overrun=0, frame_valid=0.
- frame_ack asserted in the cycle of frame 2's last event -> frame=frame 2, frame_valid stays 1, overrun=0.
- 3 bytes, then 1024 idle clks -> timeout_err pulses once, byte_idx=0. The next 6 bytes form a correct frame.
- en=0 while byte_toggle flips twice, then en=1 -> byte_idx unchanged, no spurious byte captured.
